// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR fault monitor: FSM encoding, default
// parameter values and the state decode helper.
package tmr_pkg;

  // Monitor FSM encoding; 2'b11 is never produced and is treated as LOCKED
  typedef enum logic [1:0] {
    MONITOR = 2'b00,
    RECOVER = 2'b01,
    LOCKED  = 2'b10
  } fault_state_e;

  localparam int DEF_NUM_VOTERS     = 4;
  localparam int DEF_CNT_WIDTH      = 8;
  localparam int DEF_THRESHOLD      = 16;
  localparam int DEF_PERSIST_CYCLES = 4;
  localparam int DEF_ACK_TIMEOUT    = 32;

  // Map the raw state register onto a legal state, failing safe to LOCKED
  function automatic fault_state_e decode_state(input logic [1:0] raw);
    case (raw)
      2'b00:   return MONITOR;
      2'b01:   return RECOVER;
      default: return LOCKED;
    endcase
  endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module tmr_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: clear to zero, otherwise step by one unless already at max
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tmr_fault_monitor.sv
// Fault monitor downstream of the TMR voter bank: sticky per-voter flags,
// saturating fault/run counters, recovery request with ack timeout and a
// persistent-fault lock that only a software clear releases.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int NUM_VOTERS     = DEF_NUM_VOTERS,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int PERSIST_CYCLES = DEF_PERSIST_CYCLES,
  parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [NUM_VOTERS-1:0] detected_i,
  input  logic                  clear_i,
  input  logic                  recover_ack_i,
  output logic                  recover_req_o,
  output logic                  persistent_o,
  output logic                  irq_o,
  output logic [NUM_VOTERS-1:0] fault_sticky_o,
  output logic [CNT_WIDTH-1:0]  fault_count_o,
  output logic [1:0]            state_o
);

  // Timeout counter only needs to reach ACK_TIMEOUT
  localparam int TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  localparam logic [CNT_WIDTH-1:0] THRESH_C  = CNT_WIDTH'(THRESHOLD);
  localparam logic [CNT_WIDTH-1:0] PERSIST_C = CNT_WIDTH'(PERSIST_CYCLES);
  localparam logic [TO_W-1:0]      TIMEOUT_C = TO_W'(ACK_TIMEOUT);

  logic [1:0]            state_q, state_d;
  fault_state_e          state_cur, state_nxt;
  logic                  req_q, req_d;
  logic                  pers_q, pers_d;
  logic                  irq_q, irq_d;
  logic [NUM_VOTERS-1:0] sticky_q, sticky_d;

  logic [CNT_WIDTH-1:0]  fault_cnt, run_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic [CNT_WIDTH-1:0]  fault_plus, run_plus;
  logic [TO_W-1:0]       to_plus;
  logic                  fault_inc, fault_clr;
  logic                  run_inc, run_clr;
  logic                  to_inc, to_clr;
  logic                  faulty;

  assign state_cur = decode_state(state_q);
  assign faulty    = enable_i & (|detected_i);

  // Saturated next values of each counter, used to decide transitions on
  // the same edge the counter updates
  always_comb begin
    fault_plus = (fault_cnt == {CNT_WIDTH{1'b1}}) ? fault_cnt : fault_cnt + CNT_WIDTH'(1);
    run_plus   = (run_cnt == {CNT_WIDTH{1'b1}}) ? run_cnt : run_cnt + CNT_WIDTH'(1);
    to_plus    = (to_cnt == {TO_W{1'b1}}) ? to_cnt : to_cnt + TO_W'(1);
  end

  // Monitor FSM: clear beats everything, then per-state escalation logic
  always_comb begin
    state_nxt = state_cur;
    req_d     = req_q;
    pers_d    = pers_q;
    irq_d     = 1'b0;
    sticky_d  = enable_i ? (sticky_q | detected_i) : sticky_q;
    fault_inc = 1'b0;
    fault_clr = 1'b0;
    run_inc   = 1'b0;
    run_clr   = 1'b0;
    to_inc    = 1'b0;
    to_clr    = 1'b0;

    if (clear_i) begin
      state_nxt = MONITOR;
      req_d     = 1'b0;
      pers_d    = 1'b0;
      sticky_d  = '0;
      fault_clr = 1'b1;
      run_clr   = 1'b1;
      to_clr    = 1'b1;
    end else begin
      case (state_cur)
        MONITOR: begin
          if (enable_i) begin
            fault_inc = faulty;
            run_inc   = faulty;
            run_clr   = ~faulty;
            if (faulty && (run_plus >= PERSIST_C)) begin
              state_nxt = LOCKED;
              pers_d    = 1'b1;
              irq_d     = 1'b1;
            end else if (faulty && (fault_plus >= THRESH_C)) begin
              state_nxt = RECOVER;
              req_d     = 1'b1;
              irq_d     = 1'b1;
            end
          end
        end
        RECOVER: begin
          to_inc = 1'b1;
          if (recover_ack_i) begin
            state_nxt = MONITOR;
            req_d     = 1'b0;
            fault_clr = 1'b1;
            run_clr   = 1'b1;
            to_clr    = 1'b1;
          end else if (to_plus >= TIMEOUT_C) begin
            state_nxt = LOCKED;
            req_d     = 1'b0;
            pers_d    = 1'b1;
            irq_d     = 1'b1;
            to_clr    = 1'b1;
          end
        end
        default: begin
          state_nxt = LOCKED;
          pers_d    = 1'b1;
          req_d     = 1'b0;
        end
      endcase
    end

    state_d = state_nxt;
  end

  // Status registers; reset returns to MONITOR with everything cleared
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MONITOR;
      req_q    <= 1'b0;
      pers_q   <= 1'b0;
      irq_q    <= 1'b0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pers_q   <= pers_d;
      irq_q    <= irq_d;
      sticky_q <= sticky_d;
    end
  end

  tmr_sat_counter #(.W(CNT_WIDTH)) u_fault_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (fault_clr),
    .inc_i   (fault_inc),
    .count_o (fault_cnt)
  );

  tmr_sat_counter #(.W(CNT_WIDTH)) u_run_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (run_clr),
    .inc_i   (run_inc),
    .count_o (run_cnt)
  );

  tmr_sat_counter #(.W(TO_W)) u_to_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (to_clr),
    .inc_i   (to_inc),
    .count_o (to_cnt)
  );

  assign recover_req_o  = req_q;
  assign persistent_o   = pers_q;
  assign irq_o          = irq_q;
  assign fault_sticky_o = sticky_q;
  assign fault_count_o  = fault_cnt;
  assign state_o        = state_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor: a vector table for the main
// flows plus hand-written timeout / ack-race sequences, all checked through
// an expected-value scoreboard queue.
module tb_tmr_fault_monitor;

  localparam logic [1:0] S_MON = 2'b00;
  localparam logic [1:0] S_REC = 2'b01;
  localparam logic [1:0] S_LCK = 2'b10;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] det;
    logic       clr;
    logic       ack;
    logic [1:0] st;
    logic       req;
    logic       pers;
    logic       irq;
    logic [3:0] sticky;
    logic [7:0] count;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic [3:0] detected_i = '0;
  logic       clear_i = 1'b0;
  logic       recover_ack_i = 1'b0;
  logic       recover_req_o;
  logic       persistent_o;
  logic       irq_o;
  logic [3:0] fault_sticky_o;
  logic [7:0] fault_count_o;
  logic [1:0] state_o;

  vec_t vecs[$];
  vec_t scoreboard[$];
  int   numVectors = 0;
  int   numMiscompares = 0;

  tmr_fault_monitor dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .detected_i     (detected_i),
    .clear_i        (clear_i),
    .recover_ack_i  (recover_ack_i),
    .recover_req_o  (recover_req_o),
    .persistent_o   (persistent_o),
    .irq_o          (irq_o),
    .fault_sticky_o (fault_sticky_o),
    .fault_count_o  (fault_count_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Build one record: inputs for a cycle and the outputs expected after it
  function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] det,
                              input logic clr, input logic ack, input logic [1:0] st,
                              input logic req, input logic pers, input logic irq,
                              input logic [3:0] sticky, input logic [7:0] count);
    vec_t v;
    v.rst = rst; v.en = en; v.det = det; v.clr = clr; v.ack = ack;
    v.st = st; v.req = req; v.pers = pers; v.irq = irq;
    v.sticky = sticky; v.count = count;
    return v;
  endfunction

  // Pop the expected record and compare it with the registered outputs
  task automatic checkOutput(input string name);
    vec_t e;
    numVectors++;
    if (scoreboard.size() == 0) begin
      numMiscompares++;
      $display("[TB] FAIL %s: scoreboard empty at vector %0d", name, numVectors);
      return;
    end
    e = scoreboard.pop_front();
    if (state_o !== e.st || recover_req_o !== e.req || persistent_o !== e.pers ||
        irq_o !== e.irq || fault_sticky_o !== e.sticky || fault_count_o !== e.count) begin
      numMiscompares++;
      $display("[TB] FAIL %s #%0d: got st=%b req=%b pers=%b irq=%b sticky=%b cnt=%0d, want st=%b req=%b pers=%b irq=%b sticky=%b cnt=%0d",
               name, numVectors, state_o, recover_req_o, persistent_o, irq_o,
               fault_sticky_o, fault_count_o, e.st, e.req, e.pers, e.irq, e.sticky, e.count);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, check after the edge
  task automatic applyStimulus(input vec_t v, input string name);
    @(negedge clk_i);
    rst_i         = v.rst;
    enable_i      = v.en;
    detected_i    = v.det;
    clear_i       = v.clr;
    recover_ack_i = v.ack;
    scoreboard.push_back(v);
    @(posedge clk_i);
    #1;
    checkOutput(name);
  endtask

  // Sixteen isolated pulses from a cleared MONITOR state end in RECOVER
  task automatic reachRecover(input logic [3:0] det);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(mk(0, 1, det, 0, 0, S_MON, 0, 0, 0, det, 8'(k)), "to_pulse");
      applyStimulus(mk(0, 1, 4'h0, 0, 0, S_MON, 0, 0, 0, det, 8'(k)), "to_idle");
    end
    applyStimulus(mk(0, 1, det, 0, 0, S_REC, 1, 0, 1, det, 8'd16), "to_enter_rec");
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with all voters flagging
    vecs.push_back(mk(1, 1, 4'hF, 0, 0, S_MON, 0, 0, 0, 4'h0, 8'd0));
    vecs.push_back(mk(1, 1, 4'hF, 0, 0, S_MON, 0, 0, 0, 4'h0, 8'd0));
    // Fifteen isolated faults stay below threshold
    for (int k = 1; k <= 15; k++) begin
      vecs.push_back(mk(0, 1, 4'b0010, 0, 0, S_MON, 0, 0, 0, 4'b0010, 8'(k)));
      vecs.push_back(mk(0, 1, 4'b0000, 0, 0, S_MON, 0, 0, 0, 4'b0010, 8'(k)));
    end
    // Sixteenth fault requests recovery
    vecs.push_back(mk(0, 1, 4'b0010, 0, 0, S_REC, 1, 0, 1, 4'b0010, 8'd16));
    // In RECOVER count is frozen but stickies still collect
    vecs.push_back(mk(0, 1, 4'b0100, 0, 0, S_REC, 1, 0, 0, 4'b0110, 8'd16));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 0, S_REC, 1, 0, 0, 4'b0110, 8'd16));
    // Ack returns to MONITOR, clears count, keeps stickies
    vecs.push_back(mk(0, 1, 4'b0000, 0, 1, S_MON, 0, 0, 0, 4'b0110, 8'd0));
    // Ack outside RECOVER does nothing
    vecs.push_back(mk(0, 1, 4'b0000, 0, 1, S_MON, 0, 0, 0, 4'b0110, 8'd0));
    // Four consecutive faults lock
    for (int k = 1; k <= 3; k++)
      vecs.push_back(mk(0, 1, 4'b0001, 0, 0, S_MON, 0, 0, 0, 4'b0111, 8'(k)));
    vecs.push_back(mk(0, 1, 4'b0001, 0, 0, S_LCK, 0, 1, 1, 4'b0111, 8'd4));
    // LOCKED: count frozen, ack ignored, sticky still collects
    vecs.push_back(mk(0, 1, 4'b1000, 0, 1, S_LCK, 0, 1, 0, 4'b1111, 8'd4));
    // Clear beats detected in the same cycle
    vecs.push_back(mk(0, 1, 4'b1111, 1, 0, S_MON, 0, 0, 0, 4'b0000, 8'd0));
    // Disabled monitor ignores faults
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(0, 0, 4'b1000, 0, 0, S_MON, 0, 0, 0, 4'b0000, 8'd0));
    // Persistence and threshold on the same cycle: persistence wins
    for (int k = 1; k <= 12; k++) begin
      vecs.push_back(mk(0, 1, 4'b0100, 0, 0, S_MON, 0, 0, 0, 4'b0100, 8'(k)));
      vecs.push_back(mk(0, 1, 4'b0000, 0, 0, S_MON, 0, 0, 0, 4'b0100, 8'(k)));
    end
    for (int k = 13; k <= 15; k++)
      vecs.push_back(mk(0, 1, 4'b0100, 0, 0, S_MON, 0, 0, 0, 4'b0100, 8'(k)));
    vecs.push_back(mk(0, 1, 4'b0100, 0, 0, S_LCK, 0, 1, 1, 4'b0100, 8'd16));
    // Reset overrides clear/ack/detected and does not pulse irq
    vecs.push_back(mk(1, 1, 4'hF, 1, 1, S_MON, 0, 0, 0, 4'b0000, 8'd0));

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], "table");

    // Ack timeout: 32 cycles in RECOVER without ack escalates to LOCKED
    reachRecover(4'b1000);
    for (int k = 1; k <= 31; k++)
      applyStimulus(mk(0, 1, 4'h0, 0, 0, S_REC, 1, 0, 0, 4'b1000, 8'd16), "to_wait");
    applyStimulus(mk(0, 1, 4'h0, 0, 0, S_LCK, 0, 1, 1, 4'b1000, 8'd16), "to_expire");
    applyStimulus(mk(0, 1, 4'h0, 0, 0, S_LCK, 0, 1, 0, 4'b1000, 8'd16), "to_locked_hold");
    applyStimulus(mk(0, 1, 4'h0, 1, 0, S_MON, 0, 0, 0, 4'b0000, 8'd0), "to_clear");

    // Ack on the very cycle the timeout would expire wins
    reachRecover(4'b0001);
    for (int k = 1; k <= 31; k++)
      applyStimulus(mk(0, 1, 4'h0, 0, 0, S_REC, 1, 0, 0, 4'b0001, 8'd16), "race_wait");
    applyStimulus(mk(0, 1, 4'h0, 0, 1, S_MON, 0, 0, 0, 4'b0001, 8'd0), "race_ack");
    applyStimulus(mk(0, 1, 4'h0, 0, 0, S_MON, 0, 0, 0, 4'b0001, 8'd0), "race_after");

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
